// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART definitions: transmitter FSM state encoding and default frame geometry.
package uart_tx_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam int unsigned DATA_WIDTH_DEF   = 32'd8;
    localparam int unsigned CLKS_PER_BIT_DEF = 32'd16;

endpackage

// File: rtl/uart_tx_ctrl_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps at each bit boundary, held at 0 by clear.
module uart_baud_cnt
    import uart_tx_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);
    localparam int unsigned CW = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 32'd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: cleared while idle, wraps on the last cycle of a bit
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops words from a first-word-fall-through FIFO and serialises
// them as start bit, data LSB first, optional even parity, then one or two stop bits.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned PARITY_EN    = 32'd0,
    parameter int unsigned STOP_BITS    = 32'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);
    localparam int unsigned BW = (DATA_WIDTH > 32'd1) ? $clog2(DATA_WIDTH) : 32'd1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 32'd1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(32'd1);
    localparam logic          LAST_STOP = (STOP_BITS > 32'd1) ? 1'b1 : 1'b0;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic                  par_q, par_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  bit_end_s, clear_s, pop_ok_s, launch_s, tx_done_s;

    assign clear_s  = (state_q == ST_IDLE);
    // reset gates the pop so a held-off FIFO word is never consumed during reset
    assign pop_ok_s = ~rst & enable & ~fifo_empty;

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_s),
        .bit_end (bit_end_s)
    );

    // frame sequencing; txd_d is the line level for the cycle after the edge
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_d      = par_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        launch_s   = 1'b0;
        tx_done_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_ok_s) begin
                    launch_s = 1'b1;
                end else begin
                    txd_d  = 1'b1;
                    busy_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    txd_d     = shreg_q[0];
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_idx_q == LAST_BIT)) begin
                    if (PARITY_EN != 32'd0) begin
                        state_d = ST_PARITY;
                        txd_d   = par_q;
                    end else begin
                        state_d    = ST_STOP;
                        stop_idx_d = 1'b0;
                        txd_d      = 1'b1;
                    end
                end else if (bit_end_s) begin
                    shreg_d   = shreg_q >> 1;
                    txd_d     = shreg_d[0];
                    bit_idx_d = bit_idx_q + BIT_ONE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    txd_d      = 1'b1;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s && (stop_idx_q == LAST_STOP)) begin
                    tx_done_s = 1'b1;
                    if (pop_ok_s) begin
                        launch_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        txd_d   = 1'b1;
                    end
                end else if (bit_end_s) begin
                    stop_idx_d = 1'b1;
                end else begin
                    stop_idx_d = stop_idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                txd_d   = 1'b1;
            end
        endcase
        // a launch captures the FIFO head in the same cycle as the pop
        if (launch_s) begin
            state_d    = ST_START;
            shreg_d    = fifo_data;
            par_d      = even_parity(fifo_data);
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            txd_d      = 1'b0;
            busy_d     = 1'b1;
        end else begin
            par_d = par_d;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_q      <= par_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    assign fifo_pop = launch_s;
    assign txd      = txd_q;
    assign busy     = busy_q;
    assign tx_done  = tx_done_s;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: table of single frames plus hand-written multi-cycle sequences.
module tb_uart_tx_ctrl;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_a, enable_b, fifo_empty;
    logic [7:0] fifo_data;
    logic       pop_a, txd_a, busy_a, done_a;
    logic       pop_b, txd_b, busy_b, done_b;

    logic [7:0] fifo_q[$];
    logic       s_txd_a, s_busy_a, s_done_a, s_pop_a;
    logic       s_txd_b, s_busy_b, s_done_b, s_pop_b;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         pop_viol = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .enable(enable_a), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_pop(pop_a), .txd(txd_a), .busy(busy_a), .tx_done(done_a));

    uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_pop(pop_b), .txd(txd_b), .busy(busy_b), .tx_done(done_b));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic [0:9] seq;
    } vec_t;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // FIFO head presentation; the head is scrambled whenever the FIFO is empty
    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        if (fifo_empty) fifo_data = 8'($urandom);
        else fifo_data = fifo_q[0];
    endtask

    task automatic step();
        @(negedge clk);
        s_txd_a = txd_a; s_busy_a = busy_a; s_done_a = done_a; s_pop_a = pop_a;
        s_txd_b = txd_b; s_busy_b = busy_b; s_done_b = done_b; s_pop_b = pop_b;
        if ((pop_a || pop_b) && fifo_empty) pop_viol++;
        if (pop_a && pop_b) pop_viol++;
        @(posedge clk);
        #1;
        if ((s_pop_a || s_pop_b) && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh();
    endtask

    task automatic wait_pop(input bit sel_b, input string tag);
        int got;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            step();
            if ((sel_b ? s_pop_b : s_pop_a) === 1'b1) got = 1;
        end
        check_int({tag, " pop seen"}, got, 1);
    endtask

    task automatic observe(input bit sel_b, input int n, input logic [0:79] exp, input int drop_at,
                           input string tag, output int busy_bad, output int done_cnt,
                           output int done_first, output int done_last, output int pop_cnt,
                           output int pop_idx);
        busy_bad = 0; done_cnt = 0; done_first = -1; done_last = -1; pop_cnt = 0; pop_idx = -1;
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) begin
                enable_a = 1'b0;
                enable_b = 1'b0;
            end
            step();
            check_bit($sformatf("%s txd[%0d]", tag, i), sel_b ? s_txd_b : s_txd_a, exp[i / CPB]);
            if ((sel_b ? s_busy_b : s_busy_a) !== 1'b1) busy_bad++;
            if ((sel_b ? s_done_b : s_done_a) === 1'b1) begin
                done_cnt++;
                if (done_first < 0) done_first = i;
                done_last = i;
            end
            if ((sel_b ? s_pop_b : s_pop_a) === 1'b1) begin
                pop_cnt++;
                if (pop_idx < 0) pop_idx = i;
            end
        end
    endtask

    initial begin
        vec_t vecs[4];
        int   bb, dc, df, dl, pc, pi, bad;

        vecs[0] = '{data: 8'hA5, seq: 10'b0101001011};
        vecs[1] = '{data: 8'h3C, seq: 10'b0001111001};
        vecs[2] = '{data: 8'h81, seq: 10'b0100000011};
        vecs[3] = '{data: 8'h5A, seq: 10'b0010110101};

        rst = 1'b1; enable_a = 1'b0; enable_b = 1'b0;
        fifo_q.delete();
        refresh();
        repeat (3) step();
        check_bit("reset txd_a", s_txd_a, 1'b1);
        check_bit("reset busy_a", s_busy_a, 1'b0);
        check_bit("reset done_a", s_done_a, 1'b0);
        check_bit("reset pop_a", s_pop_a, 1'b0);
        check_bit("reset txd_b", s_txd_b, 1'b1);
        rst = 1'b0;

        // empty FIFO with enable held: line must stay idle
        enable_a = 1'b1; enable_b = 1'b1; bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (s_txd_a !== 1'b1 || s_busy_a !== 1'b0 || s_done_a !== 1'b0 || s_pop_a !== 1'b0) bad++;
            if (s_txd_b !== 1'b1 || s_busy_b !== 1'b0 || s_done_b !== 1'b0 || s_pop_b !== 1'b0) bad++;
        end
        check_int("idle50 bad cycles", bad, 0);
        enable_b = 1'b0;

        // single frames from the table
        for (int v = 0; v < 4; v++) begin
            fifo_q.push_back(vecs[v].data);
            refresh();
            wait_pop(1'b0, $sformatf("vec%0d", v));
            observe(1'b0, 40, {vecs[v].seq, 70'b0}, -1, $sformatf("vec%0d", v), bb, dc, df, dl, pc, pi);
            check_int($sformatf("vec%0d busy gaps", v), bb, 0);
            check_int($sformatf("vec%0d done count", v), dc, 1);
            check_int($sformatf("vec%0d done cycle", v), dl, 39);
            check_int($sformatf("vec%0d extra pops", v), pc, 0);
            step();
            check_bit($sformatf("vec%0d busy after", v), s_busy_a, 1'b0);
            check_bit($sformatf("vec%0d txd after", v), s_txd_a, 1'b1);
        end

        // back-to-back 0x00 then 0xFF
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        refresh();
        wait_pop(1'b0, "b2b");
        observe(1'b0, 80, {10'b0000000001, 10'b0111111111, 60'b0}, -1, "b2b", bb, dc, df, dl, pc, pi);
        check_int("b2b busy gaps", bb, 0);
        check_int("b2b done count", dc, 2);
        check_int("b2b first done", df, 39);
        check_int("b2b last done", dl, 79);
        check_int("b2b pop count", pc, 1);
        check_int("b2b pop cycle", pi, 39);
        step();
        check_bit("b2b busy after", s_busy_a, 1'b0);

        // enable low holds off; enable dropped mid-frame completes without a second pop
        enable_a = 1'b0;
        fifo_q.push_back(8'h96);
        fifo_q.push_back(8'h3C);
        refresh();
        pc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_pop_a === 1'b1 || s_busy_a !== 1'b0) pc++;
        end
        check_int("disabled pops", pc, 0);
        enable_a = 1'b1;
        wait_pop(1'b0, "drop");
        observe(1'b0, 40, {10'b0011010011, 70'b0}, 12, "drop", bb, dc, df, dl, pc, pi);
        check_int("drop busy gaps", bb, 0);
        check_int("drop done cycle", dl, 39);
        check_int("drop pops in frame", pc, 0);
        pc = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_pop_a === 1'b1 || s_busy_a !== 1'b0) pc++;
        end
        check_int("drop pops after", pc, 0);
        check_int("drop queue left", fifo_q.size(), 1);
        fifo_q.delete();
        refresh();

        // even parity, two stop bits, 0x07
        enable_b = 1'b1;
        fifo_q.push_back(8'h07);
        refresh();
        wait_pop(1'b1, "par");
        observe(1'b1, 48, {12'b011100000111, 68'b0}, -1, "par", bb, dc, df, dl, pc, pi);
        check_int("par busy gaps", bb, 0);
        check_int("par done count", dc, 1);
        check_int("par done cycle", dl, 47);
        check_int("par extra pops", pc, 0);
        step();
        check_bit("par busy after", s_busy_b, 1'b0);
        enable_b = 1'b0;

        // reset during data bit 3 of 0x81, then 0xC3 is sent whole
        enable_a = 1'b1;
        fifo_q.push_back(8'h81);
        fifo_q.push_back(8'hC3);
        refresh();
        wait_pop(1'b0, "rstmid");
        observe(1'b0, 17, {10'b0100000011, 70'b0}, -1, "rstmid", bb, dc, df, dl, pc, pi);
        #2 rst = 1'b1;
        #1;
        check_bit("rstmid txd immediate", txd_a, 1'b1);
        check_bit("rstmid busy immediate", busy_a, 1'b0);
        check_bit("rstmid pop immediate", pop_a, 1'b0);
        pc = 0;
        repeat (2) begin
            step();
            if (s_pop_a === 1'b1) pc++;
        end
        check_int("rstmid pops in reset", pc, 0);
        check_int("rstmid queue left", fifo_q.size(), 1);
        rst = 1'b0;
        wait_pop(1'b0, "after rst");
        observe(1'b0, 40, {10'b0110000111, 70'b0}, -1, "after rst", bb, dc, df, dl, pc, pi);
        check_int("after rst busy gaps", bb, 0);
        check_int("after rst done cycle", dl, 39);
        check_int("after rst extra pops", pc, 0);
        step();
        check_bit("after rst busy after", s_busy_a, 1'b0);

        check_int("pop while empty", pop_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
